sprite_line_fetch: RTL and testbench

Per-scanline sequencer for the 256×16 sprite BRAM (one 32×32 sprite, 4-bit pixels, 8 words per row, 4 pixels per word, leftmost pixel in bits [15:12]). At each line start it reads the sprite row needed for the next display line into a fetch buffer, then commits it to a display buffer. During active video it emits a registered 8-bit colour index and a valid flag per pixel clock. It sits between the video timing generator and the sprite BRAM read port, and owns that read port exclusively. CPU writes go through the BRAM's separate write port.

---
 rtl/sprite_line_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_line_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
// Per-scanline sequencer for a 32x32, 4-bit-per-pixel sprite held in a
// 256x16 BRAM (8 words per row, 4 pixels per word, leftmost pixel in [15:12]).
// On each line start the previously fetched row is committed to the display
// buffer and the row needed for the next line is read into the fetch buffer.
// During active video a registered colour index and opacity flag are emitted.
//
// Ports
//   clk            pixel/system clock
//   reset_n_i      asynchronous active-low reset
//   cfg_wr_i       config write strobe
//   cfg_sel_i      0 = X, 1 = Y, 2 = CTRL (bit0 enable, [7:4] bank, bit15 clears overrun)
//   cfg_data_i     config write data
//   line_start_i   one-cycle pulse at start of each display line
//   fetch_line_i   line number to fetch for, sampled with line_start_i
//   h_count_i      current pixel column
//   spr_rd_en_o    BRAM read enable
//   spr_rd_addr_o  BRAM read address {row, word}
//   spr_rd_data_i  BRAM read data, valid one cycle after spr_rd_en_o
//   pixel_valid_o  sprite pixel opaque at this column
//   pixel_color_o  {palette bank, pixel nibble}
//   busy_o         fetch in progress
//   overrun_o      sticky: line_start_i arrived during a fetch
module sprite_line_fetch #(
    parameter int H_WIDTH = 11,
    parameter int V_WIDTH = 11
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               cfg_wr_i,
    input  logic [1:0]         cfg_sel_i,
    input  logic [15:0]        cfg_data_i,
    input  logic               line_start_i,
    input  logic [V_WIDTH-1:0] fetch_line_i,
    input  logic [H_WIDTH-1:0] h_count_i,
    output logic               spr_rd_en_o,
    output logic [7:0]         spr_rd_addr_o,
    input  logic [15:0]        spr_rd_data_i,
    output logic               pixel_valid_o,
    output logic [7:0]         pixel_color_o,
    output logic               busy_o,
    output logic               overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LAST
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [H_WIDTH-1:0] r_x;
    logic [V_WIDTH-1:0] r_y;
    logic               r_en;
    logic [3:0]         r_bank;
    logic               r_overrun;

    logic [4:0]         r_row;
    logic [2:0]         r_word;
    logic [15:0]        r_fetch [8];
    logic [15:0]        r_disp  [8];
    logic               r_fetch_ok;
    logic               r_disp_valid;
    logic               r_rd_en;
    logic [7:0]         r_rd_addr;
    logic               r_pix_valid;
    logic [7:0]         r_pix_color;

    logic [V_WIDTH-1:0] w_row;
    logic               w_busy;
    logic               w_start;
    logic [H_WIDTH-1:0] w_dx;
    logic               w_hit;
    logic [15:0]        w_word;
    logic [3:0]         w_nib;
    logic               w_unused;

    // Not every data bit maps to a register field.
    assign w_unused = ^cfg_data_i;

    // Row offset wraps modulo 2^V_WIDTH, so lines above Y land far out of range.
    assign w_row   = fetch_line_i - r_y;
    assign w_busy  = (r_state != S_IDLE);
    assign w_start = line_start_i & r_en & (w_row[V_WIDTH-1:5] == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A line start overrides whatever the sequencer was doing.
    always_comb begin
        w_state_nxt = r_state;
        if (line_start_i) begin
            w_state_nxt = w_start ? S_READ : S_IDLE;
        end else begin
            case (r_state)
                S_READ:  if (r_word == 3'd7) w_state_nxt = S_LAST;
                S_LAST:  w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ---------------- configuration ----------------
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_x       <= '0;
            r_y       <= '0;
            r_en      <= 1'b0;
            r_bank    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (cfg_wr_i) begin
                case (cfg_sel_i)
                    2'd0: r_x <= cfg_data_i[H_WIDTH-1:0];
                    2'd1: r_y <= cfg_data_i[V_WIDTH-1:0];
                    2'd2: begin
                        r_en   <= cfg_data_i[0];
                        r_bank <= cfg_data_i[7:4];
                    end
                    default: ;
                endcase
            end
            // A fresh overrun wins over a simultaneous clear request.
            if (line_start_i && w_busy) begin
                r_overrun <= 1'b1;
            end else if (cfg_wr_i && (cfg_sel_i == 2'd2) && cfg_data_i[15]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // ---------------- fetch / commit ----------------
    // r_word is the word whose address is on the bus this cycle; its data is
    // captured one cycle later, hence the slot r_word-1 in READ and slot 7 in LAST.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_row        <= '0;
            r_word       <= '0;
            r_fetch_ok   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_fetch[i] <= '0;
                r_disp[i]  <= '0;
            end
        end else begin
            r_rd_en <= 1'b0;
            if (line_start_i) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    r_disp[i] <= r_fetch[i];
                end
                r_disp_valid <= r_fetch_ok;
                r_fetch_ok   <= 1'b0;
                if (w_start) begin
                    r_row     <= w_row[4:0];
                    r_word    <= '0;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= {w_row[4:0], 3'd0};
                end
            end else begin
                case (r_state)
                    S_READ: begin
                        if (r_word != 3'd0) begin
                            r_fetch[r_word - 3'd1] <= spr_rd_data_i;
                        end
                        if (r_word != 3'd7) begin
                            r_word    <= r_word + 3'd1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= {r_row, r_word + 3'd1};
                        end
                    end
                    S_LAST: begin
                        r_fetch[7] <= spr_rd_data_i;
                        r_fetch_ok <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- pixel path ----------------
    assign w_dx  = h_count_i - r_x;
    assign w_hit = r_disp_valid & r_en & (w_dx[H_WIDTH-1:5] == '0);

    always_comb begin
        w_word = r_disp[w_dx[4:2]];
        case (w_dx[1:0])
            2'd0:    w_nib = w_word[15:12];
            2'd1:    w_nib = w_word[11:8];
            2'd2:    w_nib = w_word[7:4];
            default: w_nib = w_word[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
        end else begin
            r_pix_valid <= w_hit & (w_nib != 4'd0);
            r_pix_color <= w_hit ? {r_bank, w_nib} : '0;
        end
    end

    assign spr_rd_en_o   = r_rd_en;
    assign spr_rd_addr_o = r_rd_addr;
    assign pixel_valid_o = r_pix_valid;
    assign pixel_color_o = r_pix_color;
    assign busy_o        = w_busy;
    assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Self-checking bench for sprite_line_fetch: a line-level behavioural model
// (pixel arrays, fetch age counter) is compared against the DUT on every
// negative clock edge, plus directed literal checks.
module tb_sprite_line_fetch;

    localparam int HW = 11;
    localparam int VW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [15:0]   cfg_data = '0;
    logic          line_start = 1'b0;
    logic [VW-1:0] fetch_line = '0;
    logic [HW-1:0] h_count = '0;
    logic          rd_en;
    logic [7:0]    rd_addr;
    logic [15:0]   rd_data = '0;
    logic          pix_valid;
    logic [7:0]    pix_color;
    logic          busy;
    logic          overrun;

    logic [15:0]   mem [256];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    sprite_line_fetch #(.H_WIDTH(HW), .V_WIDTH(VW)) dut (
        .clk           (clk),
        .reset_n_i     (rst_n),
        .cfg_wr_i      (cfg_wr),
        .cfg_sel_i     (cfg_sel),
        .cfg_data_i    (cfg_data),
        .line_start_i  (line_start),
        .fetch_line_i  (fetch_line),
        .h_count_i     (h_count),
        .spr_rd_en_o   (rd_en),
        .spr_rd_addr_o (rd_addr),
        .spr_rd_data_i (rd_data),
        .pixel_valid_o (pix_valid),
        .pixel_color_o (pix_color),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    // Synchronous-read BRAM
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [HW-1:0] m_x;
    logic [VW-1:0] m_y;
    logic          m_en, m_ovr, m_fok, m_dv;
    logic [3:0]    m_bank;
    logic [4:0]    m_row;
    int            m_cnt;          // cycles since fetch start, 0 = no fetch
    logic [3:0]    m_fpx [32];     // fetched line as pixels
    logic [3:0]    m_dpx [32];     // displayed line as pixels
    logic          e_rd_en, e_valid, e_busy, e_ovr;
    logic [7:0]    e_addr, e_color;

    function automatic logic [3:0] pix_of(input logic [15:0] w, input int p);
        return w[15-4*p -: 4];
    endfunction

    task automatic m_reset();
        m_x = '0; m_y = '0; m_en = 0; m_ovr = 0; m_fok = 0; m_dv = 0;
        m_bank = '0; m_row = '0; m_cnt = 0;
        for (int k = 0; k < 32; k++) begin m_fpx[k] = '0; m_dpx[k] = '0; end
        e_rd_en = 0; e_valid = 0; e_busy = 0; e_ovr = 0; e_addr = '0; e_color = '0;
    endtask

    task automatic m_step();
        logic [HW-1:0] dx;
        logic [VW-1:0] row;
        bit was_busy;
        dx = h_count - m_x;
        if (m_dv && m_en && dx < 32) begin
            e_color = {m_bank, m_dpx[dx[4:0]]};
            e_valid = (m_dpx[dx[4:0]] != 0);
        end else begin
            e_color = '0;
            e_valid = 0;
        end
        was_busy = (m_cnt != 0);
        if (line_start) begin
            if (was_busy) m_ovr = 1;
            for (int k = 0; k < 32; k++) m_dpx[k] = m_fpx[k];
            m_dv = m_fok;
            m_fok = 0;
            row = fetch_line - m_y;
            if (m_en && row < 32) begin m_row = row[4:0]; m_cnt = 1; end
            else m_cnt = 0;
        end else if (m_cnt == 9) begin
            for (int k = 0; k < 32; k++) m_fpx[k] = pix_of(mem[int'(m_row)*8 + k/4], k%4);
            m_fok = 1;
            m_cnt = 0;
        end else if (m_cnt != 0) begin
            m_cnt++;
        end
        if (cfg_wr) begin
            case (cfg_sel)
                2'd0: m_x = cfg_data[HW-1:0];
                2'd1: m_y = cfg_data[VW-1:0];
                2'd2: begin
                    m_en = cfg_data[0];
                    m_bank = cfg_data[7:4];
                    if (cfg_data[15] && !(line_start && was_busy)) m_ovr = 0;
                end
                default: ;
            endcase
        end
        e_rd_en = (m_cnt >= 1 && m_cnt <= 8);
        if (e_rd_en) e_addr = 8'(int'(m_row)*8 + m_cnt - 1);
        e_busy = (m_cnt != 0);
        e_ovr = m_ovr;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model rd_en",   rd_en,     e_rd_en);
            chk("model rd_addr", rd_addr,   e_addr);
            chk("model busy",    busy,      e_busy);
            chk("model overrun", overrun,   e_ovr);
            chk("model valid",   pix_valid, e_valid);
            chk("model color",   pix_color, e_color);
        end
    end

    // ---------------- stimulus helpers (act at posedge+2) ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [15:0] d);
        cfg_wr = 1; cfg_sel = sel; cfg_data = d;
        cyc(1);
        cfg_wr = 0;
    endtask

    task automatic line(input logic [VW-1:0] fl);
        line_start = 1; fetch_line = fl;
        cyc(1);
        line_start = 0;
    endtask

    task automatic show(input logic [HW-1:0] h);
        h_count = h;
        cyc(1);
    endtask

    task automatic chk_pix(input string nm, input logic v, input logic [7:0] c);
        chk({nm, " valid"}, pix_valid, v);
        chk({nm, " color"}, pix_color, c);
    endtask

    initial begin
        logic [HW-1:0] hv;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a * 16'h0111 + 16'h0F0F);
        for (int k = 0; k < 8; k++) mem[16 + k] = 16'(16'h1234 + k);
        mem[24] = 16'h0F00;

        cyc(3);
        chk_on = 1;
        chk("reset rd_en", rd_en, 0);
        chk("reset busy", busy, 0);
        chk_pix("reset pix", 0, 8'h00);
        rst_n = 1;
        cyc(2);

        // basic fetch and display
        cfg(2'd0, 16'd100); cfg(2'd1, 16'd10); cfg(2'd2, 16'h0051);
        line(11'd12);
        for (int k = 0; k < 8; k++) begin
            chk("basic rd_en", rd_en, 1);
            chk("basic rd_addr", rd_addr, 16'(16 + k));
            cyc(1);
        end
        chk("basic busy T+9", busy, 1);
        chk("basic rd_en T+9", rd_en, 0);
        cyc(1);
        line(11'd13);
        chk("basic no overrun", overrun, 0);
        for (int h = 98; h <= 134; h++) begin
            show(11'(h));
            case (h)
                99:  chk_pix("basic h99", 0, 8'h00);
                100: chk_pix("basic h100", 1, 8'h51);
                101: chk_pix("basic h101", 1, 8'h52);
                102: chk_pix("basic h102", 1, 8'h53);
                103: chk_pix("basic h103", 1, 8'h54);
                131: chk_pix("basic h131", 1, 8'h5B);
                132: chk_pix("basic h132", 0, 8'h00);
                default: ;
            endcase
        end

        // transparency: row 3 word 0 = 0x0F00
        line(11'd14);
        show(11'd100); chk_pix("transp p0", 0, 8'h50);
        show(11'd101); chk_pix("transp p1", 1, 8'h5F);
        show(11'd102); chk_pix("transp p2", 0, 8'h50);
        show(11'd103); chk_pix("transp p3", 0, 8'h50);
        cyc(10);

        // out of range
        line(11'd42);
        for (int k = 0; k < 3; k++) begin
            chk("oor42 rd_en", rd_en, 0);
            chk("oor42 busy", busy, 0);
            cyc(1);
        end
        cyc(5);
        line(11'd9);
        chk("oor9 rd_en", rd_en, 0);
        chk("oor9 busy", busy, 0);
        for (int h = 98; h <= 134; h++) begin
            show(11'(h));
            if (h == 100 || h == 115) chk_pix("oor next line", 0, 8'h00);
        end

        // overrun
        line(11'd12);
        cyc(4);
        line(11'd13);
        chk("ovr set", overrun, 1);
        for (int k = 0; k < 8; k++) begin
            chk("ovr refetch rd_en", rd_en, 1);
            chk("ovr refetch addr", rd_addr, 16'(24 + k));
            cyc(1);
        end
        chk("ovr busy T+9", busy, 1);
        for (int h = 100; h <= 103; h++) begin
            show(11'(h));
            chk_pix("ovr line invalid", 0, 8'h00);
        end
        chk("ovr still set", overrun, 1);
        cfg(2'd2, 16'h8051);
        chk("ovr cleared", overrun, 0);
        cyc(10);
        line(11'd12);
        show(11'd101); chk_pix("ovr refetch shown", 1, 8'h5F);
        cyc(10);

        // horizontal wrap
        line(11'd12);
        cfg(2'd0, 16'h07F0);
        for (int i = 0; i <= 34; i++) begin
            hv = 11'(16'h07EF + i);
            show(hv);
            case (hv)
                11'h7EF: chk_pix("wrap h7EF", 0, 8'h00);
                11'h7F0: chk_pix("wrap h7F0", 1, 8'h51);
                11'h7F3: chk_pix("wrap h7F3", 1, 8'h54);
                11'h000: chk_pix("wrap h0", 1, 8'h51);
                11'h003: chk_pix("wrap h3", 1, 8'h58);
                11'h00F: chk_pix("wrap h15", 1, 8'h5B);
                11'h010: chk_pix("wrap h16", 0, 8'h00);
                default: ;
            endcase
        end

        // enable cleared mid-fetch: display gated at once, fetch completes
        show(11'd3); chk_pix("en on", 1, 8'h58);
        line(11'd12);
        cfg(2'd2, 16'h0050);
        cyc(1);
        chk_pix("en off gated", 0, 8'h00);
        chk("en off still reading", rd_en, 1);
        cyc(8);
        cfg(2'd2, 16'h0051);
        line(11'd12);
        show(11'h7F1); chk_pix("en off fetch kept", 1, 8'h52);

        // reset mid-fetch
        cfg(2'd0, 16'd100);
        cyc(10);
        line(11'd12);
        cyc(3);
        chk("rst pre rd_en", rd_en, 1);
        rst_n = 0;
        #1;
        chk("rst async rd_en", rd_en, 0);
        chk("rst async rd_addr", rd_addr, 0);
        chk("rst async busy", busy, 0);
        chk("rst async overrun", overrun, 0);
        chk_pix("rst async pix", 0, 8'h00);
        cyc(2);
        rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            chk("rst no reads", rd_en, 0);
            cyc(1);
        end
        cfg(2'd0, 16'd100); cfg(2'd1, 16'd10); cfg(2'd2, 16'h0051);
        line(11'd12);
        show(11'd100); chk_pix("rst dv cleared", 0, 8'h00);
        cyc(12);
        line(11'd13);
        show(11'd100); chk_pix("post rst display", 1, 8'h51);
        cyc(2);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
